// File: rtl/asyn_fifo_read_arbiter_if.sv
// Read-side bundle: per-channel FIFO flags/data/pop strobes plus the merged valid/ready output stream.
// master = the arbiter, slave = the FIFO controllers and downstream consumer.
interface asyn_fifo_read_arbiter_if #(
    parameter int NUM_CH     = 4,
    parameter int CH_W       = 2,
    parameter int DATA_WIDTH = 16
);
    logic [NUM_CH-1:0]            ch_empty;
    logic [NUM_CH*DATA_WIDTH-1:0] ch_rdata;
    logic [NUM_CH-1:0]            ch_mask;
    logic [NUM_CH-1:0]            ch_rd_en;
    logic                         out_valid;
    logic                         out_ready;
    logic [DATA_WIDTH-1:0]        out_data;
    logic [CH_W-1:0]              out_ch;

    modport master (
        input  ch_empty, ch_rdata, ch_mask, out_ready,
        output ch_rd_en, out_valid, out_data, out_ch
    );

    modport slave (
        output ch_empty, ch_rdata, ch_mask, out_ready,
        input  ch_rd_en, out_valid, out_data, out_ch
    );
endinterface

// File: rtl/asyn_fifo_read_arbiter.sv
// Round-robin read scheduler for NUM_CH FWFT FIFOs in one read domain: grants one channel
// per burst of up to BURST_LEN pops and merges the words into one registered valid/ready stream.
module asyn_fifo_read_arbiter #(
    parameter int NUM_CH     = 4,
    parameter int CH_W       = 2,
    parameter int DATA_WIDTH = 16,
    parameter int BURST_LEN  = 8,
    parameter int CNT_W      = 4
) (
    input  logic                         read_clk,
    input  logic                         read_rst_n,
    asyn_fifo_read_arbiter_if.master     bus,
    output logic                         busy,
    output logic [CH_W-1:0]              cur_grant
);

    typedef enum logic {IDLE, BURST} state_t;

    state_t                 state;
    logic [CH_W-1:0]        rr_ptr;
    logic [CH_W-1:0]        sel_idx;
    logic [CNT_W-1:0]       beat_cnt;
    logic [NUM_CH-1:0]      eligible;
    logic [NUM_CH-1:0]      rd_en;
    logic                   found;
    logic                   grant_ok;
    logic                   can_pop;
    logic                   out_valid_q;
    logic [DATA_WIDTH-1:0]  out_data_q;
    logic [CH_W-1:0]        out_ch_q;

    assign eligible = bus.ch_mask & ~bus.ch_empty;
    assign grant_ok = bus.ch_mask[cur_grant] & ~bus.ch_empty[cur_grant];
    // A stalled output register blocks popping but never ends the burst.
    assign can_pop  = (state == BURST) && grant_ok && (!out_valid_q || bus.out_ready);

    // First eligible channel at or after rr_ptr, wrapping past NUM_CH-1.
    always_comb begin
        found   = 1'b0;
        sel_idx = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (!found && eligible[(int'(rr_ptr) + k) % NUM_CH]) begin
                found   = 1'b1;
                sel_idx = CH_W'((int'(rr_ptr) + k) % NUM_CH);
            end
        end
    end

    always_comb begin
        rd_en            = '0;
        rd_en[cur_grant] = can_pop;
    end

    assign bus.ch_rd_en  = rd_en;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_ch    = out_ch_q;
    assign busy          = (state == BURST);

    always_ff @(posedge read_clk or negedge read_rst_n) begin
        if (!read_rst_n) begin
            state       <= IDLE;
            rr_ptr      <= '0;
            cur_grant   <= '0;
            beat_cnt    <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
        end else begin
            if (can_pop) begin
                out_valid_q <= 1'b1;
                out_data_q  <= bus.ch_rdata[int'(cur_grant)*DATA_WIDTH +: DATA_WIDTH];
                out_ch_q    <= cur_grant;
            end else if (bus.out_ready) begin
                out_valid_q <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (found) begin
                        cur_grant <= sel_idx;
                        rr_ptr    <= (sel_idx == CH_W'(NUM_CH - 1)) ? '0 : sel_idx + CH_W'(1);
                        beat_cnt  <= '0;
                        state     <= BURST;
                    end
                end
                BURST: begin
                    if (can_pop) begin
                        beat_cnt <= beat_cnt + CNT_W'(1);
                        if (beat_cnt == CNT_W'(BURST_LEN - 1)) begin
                            state <= IDLE;
                        end
                    end else if (!grant_ok) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_asyn_fifo_read_arbiter.sv
// Directed bench for asyn_fifo_read_arbiter: FIFO word n of channel c reads 16'hA000 + c*256 + n.
// Bursts are recorded per cycle and compared with hand-derived grant/beat/bubble tables.
module tb_asyn_fifo_read_arbiter;

    localparam int NUM_CH     = 4;
    localparam int CH_W       = 2;
    localparam int DATA_WIDTH = 16;

    logic            read_clk;
    logic            read_rst_n;
    logic            busy;
    logic [CH_W-1:0] cur_grant;

    int total = 0;
    int bad   = 0;

    int pushed [NUM_CH];
    int popped [NUM_CH];

    logic [NUM_CH-1:0]            ch_empty_v;
    logic [NUM_CH*DATA_WIDTH-1:0] ch_rdata_v;

    logic [15:0] exp_q [$];
    int nb;
    int b_ch    [8];
    int b_beats [8];
    int b_gap   [8];

    int rot_ch    [6] = '{0, 2, 0, 2, 0, 2};
    int rot_beats [6] = '{8, 8, 8, 8, 4, 4};
    int ee_ch     [6] = '{1, 3, 0, 1, 0, 0};
    int ee_beats  [6] = '{2, 1, 1, 1, 0, 0};

    asyn_fifo_read_arbiter_if #(.NUM_CH(NUM_CH), .CH_W(CH_W), .DATA_WIDTH(DATA_WIDTH)) bus ();

    asyn_fifo_read_arbiter #(
        .NUM_CH(NUM_CH), .CH_W(CH_W), .DATA_WIDTH(DATA_WIDTH), .BURST_LEN(8), .CNT_W(4)
    ) dut (
        .read_clk   (read_clk),
        .read_rst_n (read_rst_n),
        .bus        (bus),
        .busy       (busy),
        .cur_grant  (cur_grant)
    );

    initial read_clk = 1'b0;
    always #5 read_clk = ~read_clk;

    // FWFT FIFO stand-ins: occupancy is pushed minus popped, head word encodes channel and index.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            ch_empty_v[i] = (pushed[i] == popped[i]);
            ch_rdata_v[i*DATA_WIDTH +: DATA_WIDTH] = 16'hA000 + 16'(i * 256) + 16'(popped[i]);
        end
    end

    assign bus.ch_empty = ch_empty_v;
    assign bus.ch_rdata = ch_rdata_v;

    always @(posedge read_clk) begin
        for (int i = 0; i < NUM_CH; i++) begin
            if (bus.ch_rd_en[i]) popped[i] <= popped[i] + 1;
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic step(input int n);
        repeat (n) @(posedge read_clk);
        #2;
    endtask

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic apply_stimulus(input int ch, input int first, input int n);
        for (int k = 0; k < n; k++) exp_q.push_back(16'hA000 + 16'(ch * 256) + 16'(first + k));
    endtask

    // Records each burst (channel, pops, idle cycles before it) and scores the output stream.
    task automatic run_bursts(input int cycles);
        logic        prev_busy;
        int          idle_run;
        logic [15:0] w;
        prev_busy = 1'b0;
        idle_run  = 0;
        nb        = 0;
        for (int c = 0; c < cycles; c++) begin
            if (busy && !prev_busy) begin
                if (nb < 8) begin
                    b_ch[nb]    = int'(cur_grant);
                    b_beats[nb] = 0;
                    b_gap[nb]   = idle_run;
                end
                nb++;
            end
            if (busy) idle_run = 0;
            else      idle_run++;
            if (bus.ch_rd_en != '0 && nb > 0 && nb <= 8) b_beats[nb-1]++;
            check_output("rd_en_legal", 32'(bus.ch_rd_en & (bus.ch_empty | ~bus.ch_mask)), 32'h0);
            if (bus.out_valid) begin
                check_output("word_expected", 32'(exp_q.size() > 0), 32'h1);
                if (exp_q.size() > 0) begin
                    w = exp_q.pop_front();
                    check_output("stream_data", 32'(bus.out_data), 32'(w));
                    check_output("stream_ch", 32'(bus.out_ch), 32'(w[9:8]));
                end
            end
            prev_busy = busy;
            step(1);
        end
    endtask

    task automatic check_bursts(input string name, input int n, input int chs[6], input int beats[6]);
        check_output({name, "_count"}, 32'(nb), 32'(n));
        for (int b = 0; b < n && b < nb && b < 8; b++) begin
            check_output($sformatf("%s_ch%0d", name, b), 32'(b_ch[b]), 32'(chs[b]));
            check_output($sformatf("%s_beats%0d", name, b), 32'(b_beats[b]), 32'(beats[b]));
            if (b > 0) check_output($sformatf("%s_gap%0d", name, b), 32'(b_gap[b]), 32'h1);
        end
        check_output({name, "_leftover"}, 32'(exp_q.size()), 32'h0);
    endtask

    initial begin
        for (int i = 0; i < NUM_CH; i++) begin
            pushed[i] = 0;
            popped[i] = 0;
        end
        read_rst_n    = 1'b0;
        bus.ch_mask   = 4'hF;
        bus.out_ready = 1'b1;

        step(1);
        $display("[TB] reset values");
        check_output("rst_out_valid", 32'(bus.out_valid), 32'h0);
        check_output("rst_out_data", 32'(bus.out_data), 32'h0);
        check_output("rst_out_ch", 32'(bus.out_ch), 32'h0);
        check_output("rst_busy", 32'(busy), 32'h0);
        check_output("rst_cur_grant", 32'(cur_grant), 32'h0);
        check_output("rst_rd_en", 32'(bus.ch_rd_en), 32'h0);
        step(1);
        read_rst_n = 1'b1;
        #1;

        $display("[TB] burst cap and rotation");
        pushed[0] += 20;
        pushed[2] += 20;
        apply_stimulus(0, 0, 8);
        apply_stimulus(2, 0, 8);
        apply_stimulus(0, 8, 8);
        apply_stimulus(2, 8, 8);
        apply_stimulus(0, 16, 4);
        apply_stimulus(2, 16, 4);
        run_bursts(60);
        check_bursts("rot", 6, rot_ch, rot_beats);

        $display("[TB] single channel");
        pushed[0] += 3;
        #1;
        check_output("single_idle_busy", 32'(busy), 32'h0);
        check_output("single_idle_rd_en", 32'(bus.ch_rd_en), 32'h0);
        step(1);
        check_output("single_busy", 32'(busy), 32'h1);
        check_output("single_grant", 32'(cur_grant), 32'h0);
        check_output("single_rd_en0", 32'(bus.ch_rd_en), 32'h1);
        check_output("single_valid0", 32'(bus.out_valid), 32'h0);
        step(1);
        check_output("single_data_a", 32'(bus.out_data), 32'hA014);
        check_output("single_ch_a", 32'(bus.out_ch), 32'h0);
        check_output("single_rd_en1", 32'(bus.ch_rd_en), 32'h1);
        step(1);
        check_output("single_data_b", 32'(bus.out_data), 32'hA015);
        check_output("single_rd_en2", 32'(bus.ch_rd_en), 32'h1);
        step(1);
        check_output("single_data_c", 32'(bus.out_data), 32'hA016);
        check_output("single_valid_c", 32'(bus.out_valid), 32'h1);
        check_output("single_rd_en_end", 32'(bus.ch_rd_en), 32'h0);
        step(1);
        check_output("single_idle_again", 32'(busy), 32'h0);
        check_output("single_valid_end", 32'(bus.out_valid), 32'h0);

        $display("[TB] backpressure");
        pushed[1] += 10;
        #1;
        step(1);
        check_output("bp_grant", 32'(cur_grant), 32'h1);
        check_output("bp_rd_en", 32'(bus.ch_rd_en), 32'h2);
        step(1);
        check_output("bp_first_data", 32'(bus.out_data), 32'hA100);
        bus.out_ready = 1'b0;
        #1;
        for (int i = 0; i < 5; i++) begin
            check_output($sformatf("bp_stall_rd_en%0d", i), 32'(bus.ch_rd_en), 32'h0);
            check_output($sformatf("bp_stall_valid%0d", i), 32'(bus.out_valid), 32'h1);
            check_output($sformatf("bp_stall_data%0d", i), 32'(bus.out_data), 32'hA100);
            check_output($sformatf("bp_stall_ch%0d", i), 32'(bus.out_ch), 32'h1);
            check_output($sformatf("bp_stall_busy%0d", i), 32'(busy), 32'h1);
            step(1);
        end
        bus.out_ready = 1'b1;
        #1;
        begin
            int pops;
            pops = 0;
            for (int i = 0; i < 20; i++) begin
                if (bus.ch_rd_en != '0) pops++;
                if (!busy) break;
                step(1);
            end
            check_output("bp_pops_after_stall", 32'(pops), 32'h7);
        end
        check_output("bp_last_data", 32'(bus.out_data), 32'hA107);
        step(5);
        check_output("bp_drain_busy", 32'(busy), 32'h0);
        check_output("bp_drain_valid", 32'(bus.out_valid), 32'h0);
        check_output("bp_drain_data", 32'(bus.out_data), 32'hA109);

        $display("[TB] early end on empty");
        apply_stimulus(1, 10, 2);
        apply_stimulus(3, 0, 1);
        apply_stimulus(0, 23, 1);
        apply_stimulus(1, 12, 1);
        pushed[1] += 2;
        fork
            run_bursts(20);
            begin
                step(1);
                #1;
                pushed[0] += 1;
                pushed[3] += 1;
                step(3);
                #1;
                pushed[1] += 1;
            end
        join
        check_bursts("early", 4, ee_ch, ee_beats);

        $display("[TB] mask");
        pushed[3] += 6;
        #1;
        step(1);
        check_output("mask_grant3", 32'(cur_grant), 32'h3);
        check_output("mask_rd_en3", 32'(bus.ch_rd_en), 32'h8);
        step(2);
        check_output("mask_data_before", 32'(bus.out_data), 32'hA302);
        bus.ch_mask = 4'b0111;
        pushed[2] += 1;
        #1;
        check_output("mask_rd_en_drop", 32'(bus.ch_rd_en), 32'h0);
        check_output("mask_busy_same_cycle", 32'(busy), 32'h1);
        step(1);
        check_output("mask_idle_next", 32'(busy), 32'h0);
        step(1);
        check_output("mask_grant2", 32'(cur_grant), 32'h2);
        step(1);
        check_output("mask_data_ch2", 32'(bus.out_data), 32'hA214);
        check_output("mask_valid_ch2", 32'(bus.out_valid), 32'h1);

        $display("[TB] reset mid-burst");
        read_rst_n = 1'b0;
        #1;
        check_output("rstm_valid", 32'(bus.out_valid), 32'h0);
        check_output("rstm_rd_en", 32'(bus.ch_rd_en), 32'h0);
        check_output("rstm_busy", 32'(busy), 32'h0);
        check_output("rstm_grant", 32'(cur_grant), 32'h0);
        check_output("rstm_data", 32'(bus.out_data), 32'h0);
        step(2);
        read_rst_n = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            step(1);
            check_output($sformatf("mask_hold_busy%0d", i), 32'(busy), 32'h0);
            check_output($sformatf("mask_hold_rd_en%0d", i), 32'(bus.ch_rd_en), 32'h0);
        end
        bus.ch_mask = 4'hF;
        pushed[0] += 1;
        #1;
        step(1);
        check_output("rstm_first_grant", 32'(cur_grant), 32'h0);
        check_output("rstm_first_busy", 32'(busy), 32'h1);
        step(1);
        check_output("rstm_first_data", 32'(bus.out_data), 32'hA018);
        check_output("rstm_first_ch", 32'(bus.out_ch), 32'h0);
        step(10);
        check_output("final_busy", 32'(busy), 32'h0);
        check_output("final_valid", 32'(bus.out_valid), 32'h0);
        check_output("final_data", 32'(bus.out_data), 32'hA306);
        check_output("final_ch", 32'(bus.out_ch), 32'h3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
